// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game control path.
package snake_pkg;

   localparam int unsigned LEVEL_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_OVER  = 2'd3
   } state_e;

endpackage

// File: rtl/game_tick_ctrl_tick_counter.sv
// Period counter with >= terminal compare and a registered one-cycle tick.
module tick_counter #(
   parameter int unsigned CNT_W = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   output logic             tick
);

   logic [CNT_W-1:0] count_q, count_d;
   logic             tick_q, tick_d;

   // Next count and tick: clear on restart, advance or wrap while enabled, hold otherwise.
   always_comb begin
      count_d = count_q;
      tick_d  = 1'b0;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         // >= lets a shortened period catch a count that is already past it.
         if (count_q >= period - CNT_W'(1)) begin
            count_d = '0;
            tick_d  = 1'b1;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   // Counter and tick registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/game_tick_ctrl.sv
// Game-speed scheduler: run/pause/over FSM, speed level, and tick pacing.
module game_tick_ctrl
   import snake_pkg::*;
#(
   parameter int unsigned CNT_W     = 26,
   parameter int unsigned BASE_DIV  = 25_000_000,
   parameter int unsigned STEP_DIV  = 2_500_000,
   parameter int unsigned MAX_LEVEL = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               pause_tog,
   input  logic               speed_up,
   input  logic               game_over,
   output logic               tick,
   output logic [LEVEL_W-1:0] level,
   output logic [1:0]         state,
   output logic               running
);

   state_e             state_q, state_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               restart;
   logic               cnt_en;
   logic [CNT_W-1:0]   period;

   // FSM next state; game_over outranks pause_tog, start only acts from IDLE/OVER.
   always_comb begin
      state_d = state_q;
      restart = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               state_d = ST_RUN;
               restart = 1'b1;
            end
         end
         ST_RUN: begin
            if (game_over)      state_d = ST_OVER;
            else if (pause_tog) state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (game_over)      state_d = ST_OVER;
            else if (pause_tog) state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Level next value: cleared on restart, saturating increment while in play.
   always_comb begin
      level_d = level_q;
      if (restart) begin
         level_d = '0;
      end else if (speed_up && (state_q == ST_RUN || state_q == ST_PAUSE)
                   && level_q < LEVEL_W'(MAX_LEVEL)) begin
         level_d = level_q + LEVEL_W'(1);
      end
   end

   // State and level registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         level_q <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
      end
   end

   // Counting only in cycles that stay in RUN, so a pause or game over on the
   // terminal count suppresses that tick and freezes the count.
   assign cnt_en = (state_q == ST_RUN) && (state_d == ST_RUN);
   assign period = CNT_W'(BASE_DIV) - CNT_W'(level_q) * CNT_W'(STEP_DIV);

   tick_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (restart),
      .en     (cnt_en),
      .period (period),
      .tick   (tick)
   );

   assign state   = state_q;
   assign level   = level_q;
   assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Directed bench for game_tick_ctrl with BASE_DIV=10, STEP_DIV=2, MAX_LEVEL=3.
module tb_game_tick_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, pause_tog, speed_up, game_over;
   logic       tick, running;
   logic [2:0] level;
   logic [1:0] state;

   int total = 0;
   int bad   = 0;

   game_tick_ctrl #(
      .CNT_W     (8),
      .BASE_DIV  (10),
      .STEP_DIV  (2),
      .MAX_LEVEL (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pause_tog (pause_tog),
      .speed_up  (speed_up),
      .game_over (game_over),
      .tick      (tick),
      .level     (level),
      .state     (state),
      .running   (running)
   );

   always #5 clk = ~clk;

   // advance one cycle and settle just after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // number of steps until tick is seen, -1 if not within limit
   task automatic wait_tick(input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         step();
         if (tick === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; pause_tog = 1'b0; speed_up = 1'b0; game_over = 1'b0;
      repeat (3) step();
      total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
      total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
      total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick); end
      total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running: got %b want 0", running); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_start();
      int n;
      start = 1'b1; step(); start = 1'b0;
      total++; if (running !== 1'b1 || state !== 2'd1) begin bad++; $display("FAIL start_run: got running=%b state=%0d want 1/1", running, state); end
      total++; if (level !== 3'd0) begin bad++; $display("FAIL start_level: got %0d want 0", level); end
      wait_tick(20, n);
      total++; if (n !== 10) begin bad++; $display("FAIL start_first_tick: got %0d want 10", n); end
      wait_tick(20, n);
      total++; if (n !== 10) begin bad++; $display("FAIL start_second_tick: got %0d want 10", n); end
      wait_tick(20, n);
      total++; if (n !== 10) begin bad++; $display("FAIL start_third_tick: got %0d want 10", n); end
      step();
      total++; if (tick !== 1'b0) begin bad++; $display("FAIL tick_single_cycle: got %b want 0", tick); end
   endtask

   task automatic test_pause_terminal();
      int n;
      int seen;
      wait_tick(20, n);
      total++; if (n !== 9) begin bad++; $display("FAIL pause_align: got %0d want 9", n); end
      seen = 0;
      repeat (9) begin step(); if (tick) seen++; end
      pause_tog = 1'b1; step(); pause_tog = 1'b0;
      total++; if (state !== 2'd2 || tick !== 1'b0) begin bad++; $display("FAIL pause_enter: got state=%0d tick=%b want 2/0", state, tick); end
      repeat (19) begin step(); if (tick) seen++; end
      total++; if (seen !== 0) begin bad++; $display("FAIL pause_no_tick: got %0d ticks want 0", seen); end
      pause_tog = 1'b1; step(); pause_tog = 1'b0;
      total++; if (state !== 2'd1 || tick !== 1'b0) begin bad++; $display("FAIL pause_resume: got state=%0d tick=%b want 1/0", state, tick); end
      step();
      total++; if (tick !== 1'b1) begin bad++; $display("FAIL pause_resume_tick: got %b want 1", tick); end
      wait_tick(20, n);
      total++; if (n !== 10) begin bad++; $display("FAIL pause_after_spacing: got %0d want 10", n); end
   endtask

   task automatic test_ignored_start_run();
      int n;
      repeat (3) step();
      start = 1'b1; step(); start = 1'b0;
      total++; if (state !== 2'd1 || level !== 3'd0 || tick !== 1'b0) begin bad++; $display("FAIL run_start_ignored: got state=%0d level=%0d tick=%b want 1/0/0", state, level, tick); end
      wait_tick(20, n);
      total++; if (n !== 6) begin bad++; $display("FAIL run_start_phase: got %0d want 6", n); end
   endtask

   task automatic test_speed_up();
      int n;
      int exp_lvl [5] = '{1, 2, 3, 3, 3};
      int exp_gap [5] = '{8, 6, 4, 4, 4};
      for (int k = 0; k < 5; k++) begin
         speed_up = 1'b1; step(); speed_up = 1'b0;
         total++; if (level !== 3'(exp_lvl[k])) begin bad++; $display("FAIL speed_level_%0d: got %0d want %0d", k, level, exp_lvl[k]); end
         wait_tick(20, n);
         total++; if (n + 1 !== exp_gap[k]) begin bad++; $display("FAIL speed_gap_%0d: got %0d want %0d", k, n + 1, exp_gap[k]); end
      end
   endtask

   task automatic test_game_over();
      int n;
      int seen;
      repeat (3) step();
      game_over = 1'b1; pause_tog = 1'b1; step(); game_over = 1'b0; pause_tog = 1'b0;
      total++; if (state !== 2'd3 || running !== 1'b0) begin bad++; $display("FAIL over_state: got state=%0d running=%b want 3/0", state, running); end
      seen = (tick === 1'b1) ? 1 : 0;
      repeat (30) begin step(); if (tick) seen++; end
      total++; if (seen !== 0) begin bad++; $display("FAIL over_no_tick: got %0d ticks want 0", seen); end
      start = 1'b1; step(); start = 1'b0;
      total++; if (state !== 2'd1 || level !== 3'd0) begin bad++; $display("FAIL over_restart: got state=%0d level=%0d want 1/0", state, level); end
      wait_tick(20, n);
      total++; if (n !== 10) begin bad++; $display("FAIL over_restart_tick: got %0d want 10", n); end
   endtask

   task automatic test_mid_reset();
      int seen;
      speed_up = 1'b1; step(); step(); speed_up = 1'b0;
      total++; if (level !== 3'd2) begin bad++; $display("FAIL midrst_level_pre: got %0d want 2", level); end
      repeat (3) step();
      rst = 1'b1; step(); rst = 1'b0;
      total++; if (state !== 2'd0 || level !== 3'd0 || tick !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL midrst_clear: got state=%0d level=%0d tick=%b running=%b want 0/0/0/0", state, level, tick, running); end
      seen = 0;
      repeat (20) begin step(); if (tick) seen++; end
      total++; if (seen !== 0) begin bad++; $display("FAIL midrst_idle_ticks: got %0d want 0", seen); end
   endtask

   task automatic test_ignored_idle();
      int n;
      pause_tog = 1'b1; step(); pause_tog = 1'b0;
      total++; if (state !== 2'd0) begin bad++; $display("FAIL idle_pause_ignored: got %0d want 0", state); end
      speed_up = 1'b1; step(); speed_up = 1'b0;
      total++; if (level !== 3'd0 || state !== 2'd0 || tick !== 1'b0) begin bad++; $display("FAIL idle_speed_ignored: got level=%0d state=%0d tick=%b want 0/0/0", level, state, tick); end
      start = 1'b1; step(); start = 1'b0;
      wait_tick(20, n);
      total++; if (n !== 10) begin bad++; $display("FAIL idle_start_tick: got %0d want 10", n); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_pause_terminal();
      test_ignored_start_run();
      test_speed_up();
      test_game_over();
      test_mid_reset();
      test_ignored_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
